// File: rtl/keycode_event_unit_if.sv
// ---------------------------------------------------------------------------
// keycode_event_unit_if
//   Valid/ready event stream between keycode_event_unit (master) and the
//   game/meteor logic (slave).
//
//   evt_valid  master->slave  head of the event FIFO is present
//   evt_data   master->slave  [3]=1 press / 0 release, [2:0]=key index
//   evt_ready  slave->master  consumer takes the head when evt_valid is high
// ---------------------------------------------------------------------------
interface keycode_event_unit_if;
  logic       evt_valid;
  logic [3:0] evt_data;
  logic       evt_ready;

  modport master (
    output evt_valid,
    output evt_data,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    output evt_ready
  );
endinterface

// File: rtl/keycode_event_unit.sv
// ---------------------------------------------------------------------------
// keycode_event_unit
//   Turns the 24-bit keycode PIO (three USB HID usage codes) into filtered
//   held levels for six game keys (W, A, S, D, SPACE, ESC), one-cycle
//   press/release pulses, and a serialized press/release event stream held
//   in a small show-ahead FIFO.
//
//   Ports
//     clk          system clock
//     rst          asynchronous active-high reset
//     keycode      PIO keycode bytes [7:0], [15:8], [23:16]; 0x00 = empty,
//                  0x01 = rollover (key state is frozen)
//     frame_tick   one-cycle pulse per video frame
//     key_held     accepted held vector, idx 0=W 1=A 2=S 3=D 4=SPACE 5=ESC
//     key_press    one-cycle pulse per key on accepted 0->1
//     key_release  one-cycle pulse per key on accepted 1->0
//     evt          event stream (master modport of keycode_event_unit_if)
//     evt_count    FIFO occupancy
//     overflow     sticky flag: an event was dropped because the FIFO was full
//     overflow_clr clears overflow (a drop in the same cycle wins)
//
//   Build option
//     AUTO_REPEAT_EN  when defined, holding SPACE re-queues a SPACE press
//                     event after REPEAT_DELAY frame ticks and then every
//                     REPEAT_PERIOD frame ticks (no key_press pulse for
//                     repeats). When undefined, SPACE yields one press event.
// ---------------------------------------------------------------------------
module keycode_event_unit #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [23:0]                 keycode,
  input  logic                        frame_tick,
  output logic [5:0]                  key_held,
  output logic [5:0]                  key_press,
  output logic [5:0]                  key_release,
  keycode_event_unit_if.master        evt,
  output logic [$clog2(FIFO_DEPTH):0] evt_count,
  output logic                        overflow,
  input  logic                        overflow_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  // USB HID usage code of each game key, by key index.
  function automatic logic [7:0] key_code(input int idx);
    logic [7:0] code;
    case (idx)
      0:       code = 8'h1A; // W
      1:       code = 8'h04; // A
      2:       code = 8'h16; // S
      3:       code = 8'h07; // D
      4:       code = 8'h2C; // SPACE
      default: code = 8'h29; // ESC
    endcase
    return code;
  endfunction

  function automatic logic [2:0] onehot_to_idx(input logic [5:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 6; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // -------------------------------------------------------------------------
  // Input register and decode
  // -------------------------------------------------------------------------
  logic [23:0] kc_q, kc_d;
  logic [5:0]  cand_raw;
  logic [5:0]  cand;
  logic        rollover;
  logic [5:0]  key_held_q, key_held_d;

  assign kc_d = keycode;

  for (genvar gi = 0; gi < 6; gi++) begin : g_decode
    localparam logic [7:0] CODE = key_code(gi);
    assign cand_raw[gi] = (kc_q[7:0]   == CODE) |
                          (kc_q[15:8]  == CODE) |
                          (kc_q[23:16] == CODE);
  end

  assign rollover = (kc_q[7:0] == 8'h01) | (kc_q[15:8] == 8'h01) |
                    (kc_q[23:16] == 8'h01);

  // Rollover reports no usable key list, so hold the accepted state as-is.
  assign cand = rollover ? key_held_q : cand_raw;

  // -------------------------------------------------------------------------
  // Glitch filter
  // -------------------------------------------------------------------------
  logic [5:0]    last_cand_q, last_cand_d;
  logic [SW-1:0] stab_cnt_q, stab_cnt_d;
  logic [5:0]    key_press_q, key_press_d;
  logic [5:0]    key_release_q, key_release_d;

  always_comb begin
    last_cand_d   = last_cand_q;
    stab_cnt_d    = stab_cnt_q;
    key_held_d    = key_held_q;
    key_press_d   = '0;
    key_release_d = '0;
    if (cand != last_cand_q) begin
      last_cand_d = cand;
      stab_cnt_d  = '0;
    end else if (stab_cnt_q < SW'(STABLE_CYCLES - 1)) begin
      stab_cnt_d = stab_cnt_q + SW'(1);
    end else if (last_cand_q != key_held_q) begin
      // Stable long enough and different from what is held: accept.
      key_held_d    = last_cand_q;
      key_press_d   = last_cand_q & ~key_held_q;
      key_release_d = key_held_q & ~last_cand_q;
    end
  end

  // -------------------------------------------------------------------------
  // SPACE auto-repeat
  // -------------------------------------------------------------------------
  logic [5:0] rep_bits;

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_fire;

  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_fire  = 1'b0;
    if (key_press_d[4] || key_release_d[4]) begin
      rep_cnt_d = '0;
    end else if (key_held_q[4] && frame_tick) begin
      if (rep_cnt_q == RW'(REPEAT_DELAY - 1)) begin
        // Reloading to DELAY-PERIOD makes every following repeat land
        // PERIOD ticks apart while reusing the same terminal compare.
        rep_fire  = 1'b1;
        rep_cnt_d = RW'(REPEAT_DELAY - REPEAT_PERIOD);
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rep_cnt_q <= '0;
    else     rep_cnt_q <= rep_cnt_d;
  end

  assign rep_bits = {1'b0, rep_fire, 4'b0000};
`else
  assign rep_bits = '0;
`endif

  // -------------------------------------------------------------------------
  // Pending masks and serializer (releases first, lowest index first)
  // -------------------------------------------------------------------------
  logic [5:0] pend_press_q, pend_press_d;
  logic [5:0] pend_rel_q, pend_rel_d;
  logic       sel_is_rel;
  logic [5:0] sel_src;
  logic [5:0] sel_onehot;
  logic       push_req;
  logic [3:0] push_data;

  always_comb begin
    sel_is_rel = |pend_rel_q;
    sel_src    = sel_is_rel ? pend_rel_q : pend_press_q;
    sel_onehot = sel_src & (~sel_src + 6'd1);
    push_req   = |sel_src;
    push_data  = {~sel_is_rel, onehot_to_idx(sel_onehot)};
    // The selected bit leaves whether or not the FIFO takes it; new bits
    // OR in afterwards so a fresh event is never masked by the clear.
    pend_rel_d   = (pend_rel_q & ~(sel_is_rel ? sel_onehot : 6'd0)) |
                   key_release_d;
    pend_press_d = (pend_press_q & ~(sel_is_rel ? 6'd0 : sel_onehot)) |
                   key_press_d | rep_bits;
  end

  // -------------------------------------------------------------------------
  // Show-ahead event FIFO
  // -------------------------------------------------------------------------
  logic [3:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          fifo_valid;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic          drop;

  assign fifo_valid = (count_q != '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign pop        = fifo_valid & evt.evt_ready;

  always_comb begin
    // A simultaneous pop frees the slot the push needs.
    push       = push_req & (~fifo_full | pop);
    drop       = push_req & fifo_full & ~pop;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q;
    if (drop)              overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_data;
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kc_q          <= '0;
      last_cand_q   <= '0;
      stab_cnt_q    <= '0;
      key_held_q    <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
      pend_press_q  <= '0;
      pend_rel_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
    end else begin
      kc_q          <= kc_d;
      last_cand_q   <= last_cand_d;
      stab_cnt_q    <= stab_cnt_d;
      key_held_q    <= key_held_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      pend_press_q  <= pend_press_d;
      pend_rel_q    <= pend_rel_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign key_held      = key_held_q;
  assign key_press     = key_press_q;
  assign key_release   = key_release_q;
  assign evt.evt_valid = fifo_valid;
  assign evt.evt_data  = fifo_valid ? fifo_mem[rd_ptr_q] : 4'h0;
  assign evt_count     = count_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_keycode_event_unit.sv
// ---------------------------------------------------------------------------
// tb_keycode_event_unit
//   Directed stimulus for keycode_event_unit. A behavioural model (queue
//   FIFO, loop decode, tick counting for auto-repeat) predicts every output
//   each cycle; directed literal expectations pin the model. One line is
//   printed per consumed event.
// ---------------------------------------------------------------------------
module tb_keycode_event_unit;

  localparam int STABLE_CYCLES = 4;
  localparam int FIFO_DEPTH    = 8;
  localparam int REPEAT_DELAY  = 20;
  localparam int REPEAT_PERIOD = 6;
`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  localparam logic [7:0] KEY_CODE [6] = '{8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C, 8'h29};

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] keycode;
  logic        frame_tick;
  logic [5:0]  key_held, key_press, key_release;
  logic [3:0]  evt_count;
  logic        overflow;
  logic        overflow_clr;

  keycode_event_unit_if evt_if();

  keycode_event_unit #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .keycode     (keycode),
    .frame_tick  (frame_tick),
    .key_held    (key_held),
    .key_press   (key_press),
    .key_release (key_release),
    .evt         (evt_if.master),
    .evt_count   (evt_count),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model
  // -------------------------------------------------------------------------
  logic [23:0] m_kc;
  logic [5:0]  m_last, m_held, m_press, m_rel, m_pend_p, m_pend_r;
  int          m_same;   // consecutive cycles the candidate set was unchanged
  int          m_ticks;  // frame ticks since SPACE was accepted as pressed
  logic        m_ovf;
  logic [3:0]  m_q[$];

  function automatic logic [5:0] model_decode(input logic [23:0] kc, input logic [5:0] held);
    logic [5:0] r;
    logic       roll;
    logic [7:0] b;
    r = '0;
    roll = 1'b0;
    for (int j = 0; j < 3; j++) begin
      b = kc[j*8 +: 8];
      if (b == 8'h01) roll = 1'b1;
      for (int k = 0; k < 6; k++)
        if (b == KEY_CODE[k]) r[k] = 1'b1;
    end
    return roll ? held : r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_kc = '0; m_last = '0; m_held = '0; m_press = '0; m_rel = '0;
      m_pend_p = '0; m_pend_r = '0; m_same = 0; m_ticks = 0; m_ovf = 1'b0;
      m_q.delete();
    end else begin
      logic [5:0] cand, np, nr, pp, pr;
      logic       have, rep;
      logic [3:0] ev;
      int         qsize;
      // event selection from pending state before this edge
      pp = m_pend_p; pr = m_pend_r; have = 1'b0; ev = '0;
      for (int i = 0; i < 6 && !have; i++)
        if (pr[i]) begin have = 1'b1; ev = {1'b0, 3'(i)}; pr[i] = 1'b0; end
      for (int i = 0; i < 6 && !have; i++)
        if (pp[i]) begin have = 1'b1; ev = {1'b1, 3'(i)}; pp[i] = 1'b0; end
      // FIFO: a pop makes room before the push lands
      qsize = m_q.size();
      if (qsize > 0 && evt_if.evt_ready) void'(m_q.pop_front());
      if (have && m_q.size() < FIFO_DEPTH) m_q.push_back(ev);
      if (have && m_q.size() == FIFO_DEPTH && qsize == FIFO_DEPTH && !(evt_if.evt_ready))
        m_ovf = 1'b1;
      else if (overflow_clr)
        m_ovf = 1'b0;
      // filter: accept once the set has been unchanged STABLE_CYCLES samples
      cand = model_decode(m_kc, m_held);
      np = '0; nr = '0;
      if (cand != m_last) begin
        m_last = cand;
        m_same = 0;
      end else if (m_same < STABLE_CYCLES - 1) begin
        m_same++;
      end else if (m_last != m_held) begin
        np = m_last & ~m_held;
        nr = m_held & ~m_last;
      end
      // auto-repeat by absolute tick number since the press
      rep = 1'b0;
      if (np[4] || nr[4]) m_ticks = 0;
      else if (AR && m_held[4] && frame_tick) begin
        m_ticks++;
        if (m_ticks == REPEAT_DELAY ||
            (m_ticks > REPEAT_DELAY && (m_ticks - REPEAT_DELAY) % REPEAT_PERIOD == 0))
          rep = 1'b1;
      end
      m_held   = (m_held | np) & ~nr;
      m_press  = np;
      m_rel    = nr;
      m_pend_r = pr | nr;
      m_pend_p = pp | np | {1'b0, rep, 4'b0};
      m_kc     = keycode;
    end
  end

  // -------------------------------------------------------------------------
  // Per-cycle compare and event log
  // -------------------------------------------------------------------------
  logic [3:0] pop_log[$];

  always @(negedge clk) begin
    if (!rst) begin
      check("key_held", int'(key_held), int'(m_held));
      check("key_press", int'(key_press), int'(m_press));
      check("key_release", int'(key_release), int'(m_rel));
      check("evt_count", int'(evt_count), m_q.size());
      check("evt_valid", int'(evt_if.evt_valid), int'(m_q.size() != 0));
      check("evt_data", int'(evt_if.evt_data), (m_q.size() != 0) ? int'(m_q[0]) : 0);
      check("overflow", int'(overflow), int'(m_ovf));
      if (evt_if.evt_valid && evt_if.evt_ready) begin
        pop_log.push_back(evt_if.evt_data);
        $display("event %s key=%0d data=0x%0h t=%0t",
                 evt_if.evt_data[3] ? "press  " : "release",
                 evt_if.evt_data[2:0], evt_if.evt_data, $time);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_log(input string name, input logic [3:0] exp[$]);
    check({name, "_len"}, pop_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < pop_log.size(); i++)
      check($sformatf("%s_%0d", name, i), int'(pop_log[i]), int'(exp[i]));
    pop_log.delete();
  endtask

  initial begin
    rst = 1'b1; keycode = '0; frame_tick = 1'b0;
    evt_if.evt_ready = 1'b0; overflow_clr = 1'b0;
    cyc(3);
    check("rst_held", int'(key_held), 0);
    check("rst_valid", int'(evt_if.evt_valid), 0);
    check("rst_count", int'(evt_count), 0);
    check("rst_ovf", int'(overflow), 0);
    rst = 1'b0;
    cyc(2);

    // W press: accepted on the 6th edge after the change
    keycode = 24'h00001A;
    cyc(5);
    check("w_held_early", int'(key_held), 0);
    cyc(1);
    check("w_held", int'(key_held), 6'b000001);
    check("w_press", int'(key_press), 6'b000001);
    cyc(1);
    check("w_press_gone", int'(key_press), 0);
    check("w_count", int'(evt_count), 1);
    check("w_head", int'(evt_if.evt_data), 4'h8);
    cyc(3);

    // D, W, SPACE together with consumer ready
    keycode = 24'h2C1A07; evt_if.evt_ready = 1'b1;
    cyc(12);
    check("multi_held", int'(key_held), 6'b011001);
    check_log("multi", '{4'h8, 4'hB, 4'hC});

    // mid-operation reset with keys still down: they re-appear as presses
    rst = 1'b1;
    cyc(2);
    check("mrst_held", int'(key_held), 0);
    check("mrst_count", int'(evt_count), 0);
    rst = 1'b0;
    cyc(12);
    check_log("post_rst", '{4'h8, 4'hB, 4'hC});
    keycode = 24'h000000;
    cyc(12);
    check_log("rel_all", '{4'h0, 4'h3, 4'h4});

    // glitch shorter than the filter window
    keycode = 24'h000004;
    cyc(2);
    keycode = 24'h000000;
    cyc(10);
    check("glitch_held", int'(key_held), 0);
    check("glitch_count", int'(evt_count), 0);
    check_log("glitch", '{});

    // rollover freezes the held state
    keycode = 24'h00001A;
    cyc(10);
    check("roll_pre", int'(key_held), 6'b000001);
    pop_log.delete();
    keycode = 24'h010101;
    cyc(20);
    check("roll_held", int'(key_held), 6'b000001);
    check_log("roll", '{});
    keycode = 24'h000000;
    cyc(10);
    check_log("roll_rel", '{4'h0});

    // overflow: ten events into an eight-deep FIFO with no consumer
    evt_if.evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      keycode = 24'h00001A; cyc(8);
      keycode = 24'h000000; cyc(8);
    end
    cyc(4);
    check("ovf_count", int'(evt_count), 8);
    check("ovf_flag", int'(overflow), 1);
    overflow_clr = 1'b1;
    cyc(1);
    overflow_clr = 1'b0;
    check("ovf_clr", int'(overflow), 0);
    evt_if.evt_ready = 1'b1;
    cyc(10);
    check_log("ovf", '{4'h8, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0});

    // SPACE held across 31 frame ticks
    evt_if.evt_ready = 1'b0;
    keycode = 24'h00002C;
    cyc(10);
    for (int i = 0; i < 31; i++) begin
      frame_tick = 1'b1; cyc(1);
      frame_tick = 1'b0; cyc(1);
    end
    cyc(3);
    check("rep_count", int'(evt_count), AR ? 3 : 1);
    keycode = 24'h000000;
    cyc(10);
    check("rep_count_rel", int'(evt_count), AR ? 4 : 2);
    evt_if.evt_ready = 1'b1;
    cyc(8);
    if (AR) check_log("rep", '{4'hC, 4'hC, 4'hC, 4'h4});
    else    check_log("rep", '{4'hC, 4'h4});

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the directed sequence is bounded; never let the run hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
